// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, hazard hold and a saturating stall counter.
module pipe_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_hold,
    input  logic             i_flush,
    input  logic             i_clr_cnt,
    output logic [1:0]       o_occ,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy_q;
    logic             eff_rdy, acc, drn, stall;
    logic             load_main_in, load_main_skid, load_skid;

    assign eff_rdy = i_rdy & ~i_hold;
    assign o_vld   = (state_q != ST_EMPTY);
    assign drn     = o_vld & eff_rdy;
    assign acc     = i_vld & o_rdy & ~i_flush;
    assign stall   = o_vld & ~eff_rdy & ~i_flush;

    // With a skid entry o_rdy comes straight from a flop; without it, it looks through to downstream.
    generate
        if (SKID != 0) begin : g_skid_rdy
            assign o_rdy = rdy_q;
        end else begin : g_comb_rdy
            assign o_rdy = ~o_vld | eff_rdy;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d      = ST_FULL;
                        load_main_in = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (acc && drn) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_d   = ST_SKID;
                        load_skid = 1'b1;
                    end else if (drn) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (drn) begin
                        state_d        = ST_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            ST_FULL: o_occ = 2'd1;
            ST_SKID: o_occ = 2'd2;
            default: o_occ = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != ST_SKID);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= i_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= i_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_clr_cnt) begin
            cnt_q <= '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_data      = main_q;
    assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: three variants (skid, no skid, 3-bit counter)
// driven in lockstep and compared against a FIFO-level reference model.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0, rdy = 1'b0, hold = 1'b0, flush = 1'b0, clr = 1'b0;
    logic [31:0] data = '0;

    logic [2:0]  ordy, ovld;
    logic [31:0] odata [3];
    logic [1:0]  oocc [3];
    logic [15:0] ocnt [3];
    logic [2:0]  cnt3;

    int total = 0;
    int bad = 0;

    // Reference model: per instance a FIFO of depth 1 or 2 plus a saturating counter.
    logic [31:0] m_q [3][2];
    int          m_n [3];
    logic [15:0] m_cnt [3];
    logic [15:0] m_max [3] = '{16'hFFFF, 16'hFFFF, 16'd7};
    bit          m_skid [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(16)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .o_rdy(ordy[0]), .i_data(data),
        .o_vld(ovld[0]), .i_rdy(rdy), .o_data(odata[0]), .i_hold(hold), .i_flush(flush),
        .i_clr_cnt(clr), .o_occ(oocc[0]), .o_stall_cnt(ocnt[0]));

    pipe_stage #(.WIDTH(32), .SKID(0), .CNT_W(16)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .o_rdy(ordy[1]), .i_data(data),
        .o_vld(ovld[1]), .i_rdy(rdy), .o_data(odata[1]), .i_hold(hold), .i_flush(flush),
        .i_clr_cnt(clr), .o_occ(oocc[1]), .o_stall_cnt(ocnt[1]));

    pipe_stage #(.WIDTH(32), .SKID(1), .CNT_W(3)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .o_rdy(ordy[2]), .i_data(data),
        .o_vld(ovld[2]), .i_rdy(rdy), .o_data(odata[2]), .i_hold(hold), .i_flush(flush),
        .i_clr_cnt(clr), .o_occ(oocc[2]), .o_stall_cnt(cnt3));

    assign ocnt[2] = {13'd0, cnt3};

    function automatic bit m_rdy(int k);
        if (m_skid[k]) return m_n[k] < 2;
        return (m_n[k] == 0) || (rdy && !hold);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_n[k]    = 0;
            m_cnt[k]  = '0;
            m_q[k][0] = '0;
            m_q[k][1] = '0;
        end
    endtask

    // One clock edge: model decisions use pre-edge inputs and state.
    task automatic tick();
        bit a [3];
        bit d [3];
        bit s [3];
        bit er;
        er = rdy && !hold;
        for (int k = 0; k < 3; k++) begin
            a[k] = vld && m_rdy(k) && !flush;
            d[k] = (m_n[k] > 0) && er;
            s[k] = (m_n[k] > 0) && !er && !flush;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (clr) m_cnt[k] = '0;
            else if (s[k] && m_cnt[k] < m_max[k]) m_cnt[k] = m_cnt[k] + 16'd1;
            if (flush) begin
                m_n[k] = 0;
            end else begin
                if (d[k]) begin
                    m_q[k][0] = m_q[k][1];
                    m_n[k]    = m_n[k] - 1;
                end
                if (a[k]) begin
                    m_q[k][m_n[k]] = data;
                    m_n[k]         = m_n[k] + 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            total++; if (ovld[k] !== 1'b0) begin bad++; $display("FAIL reset_vld k=%0d got=%b exp=0", k, ovld[k]); end
            total++; if (oocc[k] !== 2'd0) begin bad++; $display("FAIL reset_occ k=%0d got=%0d exp=0", k, oocc[k]); end
            total++; if (ocnt[k] !== 16'd0) begin bad++; $display("FAIL reset_cnt k=%0d got=%0d exp=0", k, ocnt[k]); end
            total++; if (odata[k] !== 32'd0) begin bad++; $display("FAIL reset_data k=%0d got=%h exp=0", k, odata[k]); end
            total++; if (ordy[k] !== 1'b1) begin bad++; $display("FAIL reset_rdy k=%0d got=%b exp=1", k, ordy[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        rdy = 1'b1; hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vld  = 1'b1;
            exp  = 32'(i + 1) * 32'h11;
            data = exp;
            tick();
            for (int k = 0; k < 3; k++) begin
                total++; if (ovld[k] !== 1'b1) begin bad++; $display("FAIL stream_vld k=%0d got=%b exp=1", k, ovld[k]); end
                total++; if (odata[k] !== exp) begin bad++; $display("FAIL stream_data k=%0d got=%h exp=%h", k, odata[k], exp); end
                total++; if (oocc[k] !== 2'd1) begin bad++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, oocc[k]); end
                total++; if (ocnt[k] !== 16'd0) begin bad++; $display("FAIL stream_cnt k=%0d got=%0d exp=0", k, ocnt[k]); end
            end
        end
        vld = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++; if (ovld[k] !== 1'b0) begin bad++; $display("FAIL stream_drain k=%0d got=%b exp=0", k, ovld[k]); end
        end
    endtask

    task automatic test_skid();
        logic [31:0] got [$];
        logic [31:0] exp_seq [3];
        bit acc0;
        exp_seq = '{32'hA, 32'hB, 32'hC};
        rdy = 1'b0; vld = 1'b1;
        data = 32'hA; tick();
        data = 32'hB; tick();
        total++; if (ordy[0] !== 1'b0) begin bad++; $display("FAIL skid_rdy_low got=%b exp=0", ordy[0]); end
        total++; if (oocc[0] !== 2'd2) begin bad++; $display("FAIL skid_occ got=%0d exp=2", oocc[0]); end
        total++; if (odata[0] !== 32'hA) begin bad++; $display("FAIL skid_head got=%h exp=a", odata[0]); end
        data = 32'hC; tick();
        total++; if (oocc[0] !== 2'd2) begin bad++; $display("FAIL skid_c_refused got=%0d exp=2", oocc[0]); end
        rdy = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (ovld[0]) got.push_back(odata[0]);
            for (int k = 0; k < 3; k++) begin
                total++; if (ovld[k] !== (m_n[k] > 0)) begin bad++; $display("FAIL skid_vld k=%0d got=%b exp=%b", k, ovld[k], m_n[k] > 0); end
                if (m_n[k] > 0) begin
                    total++; if (odata[k] !== m_q[k][0]) begin bad++; $display("FAIL skid_data k=%0d got=%h exp=%h", k, odata[k], m_q[k][0]); end
                end
            end
            acc0 = vld && m_rdy(0);
            tick();
            if (acc0) vld = 1'b0;
        end
        vld = 1'b0;
        total++; if (got.size() != 3) begin bad++; $display("FAIL skid_count got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL skid_order i=%0d got=%h exp=%h", i, got[i], exp_seq[i]); end
        end
    endtask

    task automatic test_flush();
        rdy = 1'b0; vld = 1'b1;
        data = 32'h1; tick();
        data = 32'h2; tick();
        total++; if (oocc[0] !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", oocc[0]); end
        flush = 1'b1; data = 32'hDD; tick();
        flush = 1'b0; vld = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            total++; if (ovld[k] !== 1'b0) begin bad++; $display("FAIL flush_vld k=%0d got=%b exp=0", k, ovld[k]); end
            total++; if (oocc[k] !== 2'd0) begin bad++; $display("FAIL flush_occ k=%0d got=%0d exp=0", k, oocc[k]); end
            total++; if (ordy[k] !== 1'b1) begin bad++; $display("FAIL flush_rdy k=%0d got=%b exp=1", k, ordy[k]); end
        end
        rdy = 1'b1;
        repeat (3) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++; if (ovld[k] !== 1'b0) begin bad++; $display("FAIL flush_leak k=%0d got=%b exp=0", k, ovld[k]); end
            end
        end
    endtask

    task automatic test_hold();
        clr = 1'b1; vld = 1'b0; tick();
        clr = 1'b0;
        rdy = 1'b1; vld = 1'b1; data = 32'h5A5A; tick();
        vld = 1'b0; hold = 1'b1;
        repeat (5) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                total++; if (odata[k] !== 32'h5A5A || ovld[k] !== 1'b1) begin bad++; $display("FAIL hold_stable k=%0d got=%h exp=5a5a", k, odata[k]); end
            end
        end
        for (int k = 0; k < 3; k++) begin
            total++; if (ocnt[k] !== 16'd5) begin bad++; $display("FAIL hold_cnt k=%0d got=%0d exp=5", k, ocnt[k]); end
        end
        clr = 1'b1; tick(); clr = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++; if (ocnt[k] !== 16'd0) begin bad++; $display("FAIL hold_clr k=%0d got=%0d exp=0", k, ocnt[k]); end
        end
        hold = 1'b0; tick();
    endtask

    task automatic test_saturate();
        clr = 1'b1; tick(); clr = 1'b0;
        rdy = 1'b0; vld = 1'b1; data = 32'h77; tick();
        vld = 1'b0;
        repeat (8) tick();
        total++; if (ocnt[2] !== 16'd7) begin bad++; $display("FAIL sat_reach got=%0d exp=7", ocnt[2]); end
        repeat (2) tick();
        total++; if (ocnt[2] !== 16'd7) begin bad++; $display("FAIL sat_stay got=%0d exp=7", ocnt[2]); end
        total++; if (ocnt[0] !== 16'd10) begin bad++; $display("FAIL sat_wide got=%0d exp=10", ocnt[0]); end
        rdy = 1'b1; clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_async_reset();
        rdy = 1'b0; vld = 1'b1;
        data = 32'h31; tick();
        data = 32'h32; tick();
        vld = 1'b0;
        total++; if (oocc[0] !== 2'd2) begin bad++; $display("FAIL arst_pre_occ got=%0d exp=2", oocc[0]); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            total++; if (ovld[k] !== 1'b0) begin bad++; $display("FAIL arst_vld k=%0d got=%b exp=0", k, ovld[k]); end
            total++; if (odata[k] !== 32'd0) begin bad++; $display("FAIL arst_data k=%0d got=%h exp=0", k, odata[k]); end
            total++; if (oocc[k] !== 2'd0) begin bad++; $display("FAIL arst_occ k=%0d got=%0d exp=0", k, oocc[k]); end
            total++; if (ordy[k] !== 1'b1) begin bad++; $display("FAIL arst_rdy k=%0d got=%b exp=1", k, ordy[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            vld   = ($urandom_range(0, 3) != 0);
            data  = $urandom;
            rdy   = ($urandom_range(0, 3) != 0);
            hold  = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            #1;
            for (int k = 0; k < 3; k++) begin
                total++; if (ovld[k] !== (m_n[k] > 0)) begin bad++; $display("FAIL rnd_vld c=%0d k=%0d got=%b exp=%b", c, k, ovld[k], m_n[k] > 0); end
                total++; if (ordy[k] !== m_rdy(k)) begin bad++; $display("FAIL rnd_rdy c=%0d k=%0d got=%b exp=%b", c, k, ordy[k], m_rdy(k)); end
                total++; if (oocc[k] !== 2'(m_n[k])) begin bad++; $display("FAIL rnd_occ c=%0d k=%0d got=%0d exp=%0d", c, k, oocc[k], m_n[k]); end
                total++; if (ocnt[k] !== m_cnt[k]) begin bad++; $display("FAIL rnd_cnt c=%0d k=%0d got=%0d exp=%0d", c, k, ocnt[k], m_cnt[k]); end
                if (m_n[k] > 0) begin
                    total++; if (odata[k] !== m_q[k][0]) begin bad++; $display("FAIL rnd_data c=%0d k=%0d got=%h exp=%h", c, k, odata[k], m_q[k][0]); end
                end
            end
            tick();
        end
        vld = 1'b0; flush = 1'b0; clr = 1'b0; hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_hold();
        test_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
